// File: rtl/div_pkg.sv
// Shared definitions for the MD-unit sequential divider: FSM encoding,
// fixed latency used by the stall logic, and the divide-by-zero fill value.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } div_state_t;

    // Width of the pipeline's MD unit datapath.
    localparam int DIV_WIDTH = 32;

    // Cycles from the start-accept cycle to the done cycle (PREP + ITER + FIX + 1).
    localparam int LATENCY = DIV_WIDTH + 3;

    // Divide-by-zero quotient is this bit replicated across the result width.
    localparam logic DBZ_QUO_BIT = 1'b1;

    // Latency for a divider of arbitrary width.
    function automatic int div_latency(input int width);
        return width + 3;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem,quo} left, try subtracting the
// divisor, keep the difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem is always below the divisor, so the shifted value is below
    // 2*divisor and the WIDTH+1 bit difference never wraps ambiguously.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial    = shifted - {1'b0, divisor};
    assign rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle,
// fixed latency of WIDTH+3 cycles from start acceptance to the done pulse.
//
// Handshake: start is taken on a rising clk edge only when busy=0 and
// flush=0; busy is high from the cycle after acceptance until the cycle
// before done; done is a one-cycle pulse with busy=0, and quotient,
// remainder and div_by_zero stay stable until the next done pulse.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic             signed_q;
    logic             b_zero_q;
    logic             quo_neg_q;
    logic             rem_neg_q;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (div_r),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Control FSM and datapath registers; flush beats every other request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            counter     <= '0;
            a_q         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            div_r       <= '0;
            signed_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            counter <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        quo_r    <= a;
                        div_r    <= b;
                        rem_r    <= '0;
                        signed_q <= is_signed;
                        b_zero_q <= (b == '0);
                        busy     <= 1'b1;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    // Work on magnitudes; the most negative value maps to
                    // itself, which is its correct unsigned magnitude.
                    quo_neg_q <= signed_q & (quo_r[WIDTH-1] ^ div_r[WIDTH-1]);
                    rem_neg_q <= signed_q & quo_r[WIDTH-1];
                    if (signed_q && quo_r[WIDTH-1]) quo_r <= -quo_r;
                    if (signed_q && div_r[WIDTH-1]) div_r <= -div_r;
                    rem_r   <= '0;
                    counter <= CNT_W'(WIDTH);
                    state   <= S_ITER;
                end
                S_ITER: begin
                    rem_r   <= step_rem;
                    quo_r   <= step_quo;
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) state <= S_FIX;
                end
                S_FIX: begin
                    if (b_zero_q) begin
                        quotient    <= {WIDTH{DBZ_QUO_BIT}};
                        remainder   <= a_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient    <= quo_neg_q ? -quo_r : quo_r;
                        remainder   <= rem_neg_q ? -rem_r : rem_r;
                        div_by_zero <= 1'b0;
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
